// File: rtl/mem_access_sequencer.sv
// Memory-stage access sequencer: direct, byte and multi-level indirect loads/stores
// against a single-ported data memory, with pipeline abort and drain handling.
module mem_access_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MAX_IND = 1,
  parameter int unsigned LANES   = WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [$clog2(MAX_IND+1)-1:0] req_ind,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WIDTH-1:0]             req_wdata,
  input  logic                         abort,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [WIDTH-1:0]             mem_wdata,
  output logic [LANES-1:0]             mem_byte_enable,
  input  logic                         mem_resp,
  input  logic [WIDTH-1:0]             mem_rdata,
  output logic                         rsp_valid,
  output logic [WIDTH-1:0]             rsp_rdata,
  output logic                         stall
);

  localparam int unsigned IndW  = $clog2(MAX_IND + 1);
  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {StIdle, StInd, StAcc, StResp, StDrain} state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [IndW-1:0]    ind_cnt_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [ADDR_W-1:0]  mem_address_q;
  logic [WIDTH-1:0]   mem_wdata_q;
  logic [LANES-1:0]   mem_be_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_rdata_q;

  logic [IndW-1:0]    ind_clamped;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  acc_addr;
  logic [1:0]         acc_op;
  logic [WIDTH-1:0]   acc_wd;
  logic [LaneW-1:0]   acc_lane;
  logic [LaneW-1:0]   cur_lane;
  logic               acc_read;
  logic               acc_write;
  logic [LANES-1:0]   acc_be;
  logic [WIDTH-1:0]   acc_wdata;
  logic [WIDTH-1:0]   rd_shifted;
  logic [WIDTH-1:0]   load_data;

  // op encoding: bit 0 selects store, bit 1 selects byte access
  always_comb begin
    ind_clamped = req_ind;
    if (32'(req_ind) > MAX_IND) begin
      ind_clamped = IndW'(MAX_IND);
    end
  end

  assign rd_addr = mem_rdata[ADDR_W-1:0];

  // The final access is set up either straight from the request or from the last pointer read.
  always_comb begin
    acc_addr  = (state_q == StIdle) ? req_addr  : rd_addr;
    acc_op    = (state_q == StIdle) ? req_op    : op_q;
    acc_wd    = (state_q == StIdle) ? req_wdata : wdata_q;
    acc_lane  = acc_addr[LaneW-1:0];
    acc_read  = ~acc_op[0];
    acc_write = acc_op[0];
    acc_be    = '1;
    acc_wdata = '0;
    if (acc_op[0]) begin
      if (acc_op[1]) begin
        acc_be           = '0;
        acc_be[acc_lane] = 1'b1;
        acc_wdata        = {LANES{acc_wd[7:0]}};
      end else begin
        acc_wdata = acc_wd;
      end
    end
  end

  always_comb begin
    cur_lane   = addr_q[LaneW-1:0];
    rd_shifted = mem_rdata >> {cur_lane, 3'b000};
    load_data  = op_q[1] ? WIDTH'(rd_shifted[7:0]) : mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= '0;
      wdata_q       <= '0;
      addr_q        <= '0;
      ind_cnt_q     <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q          <= req_op;
            wdata_q       <= req_wdata;
            addr_q        <= req_addr;
            ind_cnt_q     <= ind_clamped;
            mem_address_q <= req_addr;
            if (ind_clamped != '0) begin
              state_q     <= StInd;
              mem_read_q  <= 1'b1;
              mem_write_q <= 1'b0;
              mem_be_q    <= '1;
              mem_wdata_q <= '0;
            end else begin
              state_q     <= StAcc;
              mem_read_q  <= acc_read;
              mem_write_q <= acc_write;
              mem_be_q    <= acc_be;
              mem_wdata_q <= acc_wdata;
            end
          end
        end
        StInd: begin
          if (mem_resp) begin
            addr_q    <= rd_addr;
            ind_cnt_q <= ind_cnt_q - IndW'(1);
            if (abort) begin
              state_q    <= StIdle;
              mem_read_q <= 1'b0;
            end else if (ind_cnt_q > IndW'(1)) begin
              mem_address_q <= rd_addr;
            end else begin
              state_q       <= StAcc;
              mem_address_q <= rd_addr;
              mem_read_q    <= acc_read;
              mem_write_q   <= acc_write;
              mem_be_q      <= acc_be;
              mem_wdata_q   <= acc_wdata;
            end
          end else if (abort) begin
            state_q <= StDrain;
          end
        end
        StAcc: begin
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (abort) begin
              state_q <= StIdle;
            end else begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              if (!op_q[0]) begin
                rsp_rdata_q <= load_data;
              end
            end
          end else if (abort) begin
            state_q <= StDrain;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        StDrain: begin
          // Wait out the outstanding access; its data is discarded.
          if (mem_resp) begin
            state_q     <= StIdle;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready       = (state_q == StIdle);
  assign stall           = (state_q != StIdle);
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer (WIDTH=16, ADDR_W=16, MAX_IND=2).
module tb_mem_access_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_ind;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        abort;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  int acc_cnt = 0;
  int both_cnt = 0;

  mem_access_sequencer #(
    .WIDTH   (16),
    .ADDR_W  (16),
    .MAX_IND (2)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_ind         (req_ind),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .abort           (abort),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .stall           (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (mem_resp && (mem_read || mem_write)) acc_cnt <= acc_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] ind, input logic [15:0] addr,
                       input logic [15:0] wd);
    req_valid = 1'b1;
    req_op    = op;
    req_ind   = ind;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  int rc0;
  int ac0;
  logic [6:0] ready_exp;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_ind = '0; req_addr = '0;
    req_wdata = '0; abort = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check_eq("rst_addr", 32'(mem_address), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_be", 32'(mem_byte_enable), 32'd0);
    check_eq("rst_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Direct word load
    issue(2'b00, 2'd0, 16'h0040, 16'h0000);
    check_eq("ld_c1_strobes", {30'd0, mem_read, mem_write}, 32'h2);
    check_eq("ld_c1_addr", 32'(mem_address), 32'h0040);
    check_eq("ld_c1_ready_stall", {30'd0, req_ready, stall}, 32'h1);
    mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_resp = 1'b0;
    check_eq("ld_c2_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("ld_c2_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
    check_eq("ld_c2_read_low", 32'(mem_read), 32'd0);
    check_eq("ld_c2_ready", 32'(req_ready), 32'd0);
    tick();
    check_eq("ld_c3_ready", 32'(req_ready), 32'd1);
    check_eq("ld_c3_rsp_valid", 32'(rsp_valid), 32'd0);

    // High-lane byte store
    rc0 = rsp_cnt;
    issue(2'b11, 2'd0, 16'h0041, 16'h12A5);
    check_eq("sb_strobes", {30'd0, mem_read, mem_write}, 32'h1);
    check_eq("sb_wdata", 32'(mem_wdata), 32'hA5A5);
    check_eq("sb_be", 32'(mem_byte_enable), 32'h2);
    check_eq("sb_addr", 32'(mem_address), 32'h0041);
    mem_resp = 1'b1; mem_rdata = 16'h0000;
    tick();
    mem_resp = 1'b0;
    check_eq("sb_write_low", 32'(mem_write), 32'd0);
    check_eq("sb_rdata_kept", 32'(rsp_rdata), 32'hBEEF);
    tick();
    check_eq("sb_rsp_once", 32'(rsp_cnt - rc0), 32'd1);

    // Two-level indirect byte load
    issue(2'b10, 2'd2, 16'h0100, 16'h0000);
    check_eq("ind_p1_addr", 32'(mem_address), 32'h0100);
    check_eq("ind_p1_read_be", {29'd0, mem_read, mem_byte_enable}, 32'h7);
    mem_resp = 1'b1; mem_rdata = 16'h0200;
    tick();
    check_eq("ind_p2_addr", 32'(mem_address), 32'h0200);
    check_eq("ind_p2_read", 32'(mem_read), 32'd1);
    mem_rdata = 16'h0301;
    tick();
    check_eq("ind_acc_addr", 32'(mem_address), 32'h0301);
    check_eq("ind_acc_read", 32'(mem_read), 32'd1);
    mem_rdata = 16'h7F3C;
    tick();
    mem_resp = 1'b0;
    check_eq("ind_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("ind_rsp_rdata", 32'(rsp_rdata), 32'h007F);
    check_eq("ind_read_low", 32'(mem_read), 32'd0);
    tick();

    // Abort during indirect read with 3 wait states
    rc0 = rsp_cnt; ac0 = acc_cnt;
    issue(2'b00, 2'd1, 16'h0080, 16'h0000);
    check_eq("ab_c1_read", 32'(mem_read), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_c2_read_addr", {15'd0, mem_read, mem_address}, 32'h1_0080);
    check_eq("ab_c2_stall", 32'(stall), 32'd1);
    tick();
    check_eq("ab_c3_read", 32'(mem_read), 32'd1);
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h0999;
    tick();
    mem_resp = 1'b0;
    check_eq("ab_c5_read_low", 32'(mem_read), 32'd0);
    check_eq("ab_c5_idle", 32'(req_ready), 32'd1);
    tick();
    check_eq("ab_no_rsp", 32'(rsp_cnt - rc0), 32'd0);
    check_eq("ab_one_access", 32'(acc_cnt - ac0), 32'd1);
    check_eq("ab_rdata_kept", 32'(rsp_rdata), 32'h007F);

    // Abort coinciding with the response
    rc0 = rsp_cnt;
    issue(2'b00, 2'd0, 16'h0050, 16'h0000);
    abort = 1'b1; mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    abort = 1'b0; mem_resp = 1'b0;
    check_eq("abr_idle", 32'(req_ready), 32'd1);
    check_eq("abr_read_low", 32'(mem_read), 32'd0);
    tick();
    check_eq("abr_no_rsp", 32'(rsp_cnt - rc0), 32'd0);
    check_eq("abr_rdata_kept", 32'(rsp_rdata), 32'h007F);

    // Reset during a store wait
    issue(2'b01, 2'd0, 16'h0060, 16'h3C5A);
    check_eq("rs_write", 32'(mem_write), 32'd1);
    check_eq("rs_wdata_be", {14'd0, mem_byte_enable, mem_wdata}, 32'h3_3C5A);
    tick();
    #3 reset = 1'b1;
    #1;
    check_eq("rs_async_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check_eq("rs_async_ready_stall", {30'd0, req_ready, stall}, 32'h2);
    check_eq("rs_async_addr_be", {14'd0, mem_byte_enable, mem_address}, 32'd0);
    check_eq("rs_async_rdata", 32'(rsp_rdata), 32'd0);
    #2 reset = 1'b0;
    tick();
    rc0 = rsp_cnt;
    mem_resp = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_resp = 1'b0;
    check_eq("rs_late_ready", 32'(req_ready), 32'd1);
    tick();
    check_eq("rs_late_no_rsp", 32'(rsp_cnt - rc0), 32'd0);
    issue(2'b00, 2'd0, 16'h0070, 16'h0000);
    check_eq("rs_new_addr", 32'(mem_address), 32'h0070);
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_resp = 1'b0;
    check_eq("rs_new_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'h1_1234);
    tick();

    // Clamp: req_ind=3 with MAX_IND=2 gives two pointer reads
    issue(2'b00, 2'd3, 16'h0010, 16'h0000);
    check_eq("cl_a1", 32'(mem_address), 32'h0010);
    mem_resp = 1'b1; mem_rdata = 16'h0020;
    tick();
    check_eq("cl_a2", 32'(mem_address), 32'h0020);
    mem_rdata = 16'h0030;
    tick();
    check_eq("cl_a3", 32'(mem_address), 32'h0030);
    mem_rdata = 16'h5555;
    tick();
    mem_resp = 1'b0;
    check_eq("cl_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'h1_5555);
    tick();

    // Back-to-back direct loads with req_valid held
    ready_exp = 7'b1001001;
    for (int c = 0; c < 7; c++) begin
      check_eq($sformatf("bb_ready_c%0d", c), 32'(req_ready), 32'(ready_exp[c]));
      check_eq($sformatf("bb_stall_c%0d", c), 32'(stall), 32'(!ready_exp[c]));
      check_eq($sformatf("bb_read_c%0d", c), 32'(mem_read), 32'((c == 1) || (c == 4)));
      if (c == 2 || c == 5) begin
        check_eq($sformatf("bb_rsp_c%0d", c), {15'd0, rsp_valid, rsp_rdata},
                 32'h1_0000 | 32'(16'h1000 + 16'(c - 1)));
      end
      mem_resp  = mem_read;
      mem_rdata = 16'h1000 + 16'(c);
      req_valid = (c <= 3);
      req_op    = 2'b00;
      req_ind   = 2'd0;
      req_addr  = 16'h0200 + 16'(c);
      tick();
    end
    req_valid = 1'b0;
    mem_resp  = 1'b0;
    tick();

    check_eq("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
